cache_req_issuer: RTL and testbench

//  Initiator side of the cache_4way_64KB request interface (iRd/iWr/iAddr/iData -> oData/oReady/oHit).

---
 rtl/cache_req_issuer.sv | 206 ++++++++++++++++++++
 tb/tb_cache_req_issuer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_issuer.sv
// Queues CPU load/store requests and issues them one at a time to the cache, returning one response per access.
// Cache outputs are one cycle after the IDLE pop; upstream stalls when the queue is full or a response is unaccepted.

module cache_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         ready_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ready_q;
    logic          do_push, do_pop;

    // Ready is registered from the next count, so a same-cycle pop never opens the door early.
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign ready_o = ready_q;
endmodule

module cache_req_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iReqValid,
    input  logic             iReqWr,
    input  logic [31:0]      iReqAddr,
    input  logic [31:0]      iReqData,
    output logic             oReqReady,
    output logic             oRd,
    output logic             oWr,
    output logic [31:0]      oAddr,
    output logic [31:0]      oData,
    input  logic [31:0]      iData,
    input  logic             iReady,
    input  logic             iHit,
    output logic             oRspValid,
    input  logic             iRspReady,
    output logic [31:0]      oRspData,
    output logic             oRspHit,
    output logic             oRspErr,
    output logic [CNT_W-1:0] oHitCnt,
    output logic [CNT_W-1:0] oMissCnt
);
    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int             TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    cmd_t             cmd_q, cmd_d, fifo_head;
    logic [TW-1:0]    timer_q, timer_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_hit_q, rsp_hit_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             fifo_pop, fifo_empty;
    cmd_t             req_in;

    assign req_in = '{wr: iReqWr, addr: iReqAddr, data: iReqData};

    cache_req_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (iReqValid),
        .data_i  (req_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .ready_o (oReqReady)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        timer_d    = timer_q;
        rsp_data_d = rsp_data_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_err_d  = rsp_err_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_head;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion arriving on the last timer cycle still counts as a completion.
                if (iReady) begin
                    rsp_data_d = cmd_q.wr ? 32'd0 : iData;
                    rsp_hit_d  = iHit;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                    if (iHit && (hit_cnt_q != {CNT_W{1'b1}}))
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    if (!iHit && (miss_cnt_q != {CNT_W{1'b1}}))
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                end else if (timer_q == TMAX) begin
                    rsp_data_d = 32'd0;
                    rsp_hit_d  = 1'b0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                if (iRspReady) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            timer_q    <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            timer_q    <= timer_d;
            rsp_data_q <= rsp_data_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_err_q  <= rsp_err_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign oRd       = (state_q == ISSUE) && !cmd_q.wr;
    assign oWr       = (state_q == ISSUE) &&  cmd_q.wr;
    assign oAddr     = (state_q == ISSUE) ? cmd_q.addr : 32'd0;
    assign oData     = (state_q == ISSUE) ? cmd_q.data : 32'd0;
    assign oRspValid = (state_q == RESP);
    assign oRspData  = (state_q == RESP) ? rsp_data_q : 32'd0;
    assign oRspHit   = (state_q == RESP) && rsp_hit_q;
    assign oRspErr   = (state_q == RESP) && rsp_err_q;
    assign oHitCnt   = hit_cnt_q;
    assign oMissCnt  = miss_cnt_q;
endmodule

// File: tb/tb_cache_req_issuer.sv
// Directed bench for cache_req_issuer with a small address-keyed cache stand-in answering accesses.
module tb_cache_req_issuer;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             iReqValid, iReqWr;
    logic [31:0]      iReqAddr, iReqData;
    logic             oReqReady, oRd, oWr;
    logic [31:0]      oAddr, oData, iData;
    logic             iReady, iHit;
    logic             oRspValid, iRspReady;
    logic [31:0]      oRspData;
    logic             oRspHit, oRspErr;
    logic [CNT_W-1:0] oHitCnt, oMissCnt;

    logic        cache_rdy, cache_hit, man_rdy, man_hit;
    logic [31:0] cache_data, man_data;

    always #5 clk = ~clk;

    cache_req_issuer #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .iReqValid(iReqValid), .iReqWr(iReqWr), .iReqAddr(iReqAddr), .iReqData(iReqData),
        .oReqReady(oReqReady),
        .oRd(oRd), .oWr(oWr), .oAddr(oAddr), .oData(oData),
        .iData(iData), .iReady(iReady), .iHit(iHit),
        .oRspValid(oRspValid), .iRspReady(iRspReady),
        .oRspData(oRspData), .oRspHit(oRspHit), .oRspErr(oRspErr),
        .oHitCnt(oHitCnt), .oMissCnt(oMissCnt)
    );

    assign iReady = cache_rdy | man_rdy;
    assign iHit   = cache_rdy ? cache_hit  : man_hit;
    assign iData  = cache_rdy ? cache_data : man_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Cache stand-in: hit when the address was touched before; stores return junk data.
    logic [31:0] mem [logic [31:0]];
    bit          resp_en = 1'b1;
    int          resp_dly = 3;
    logic [31:0] r_addr, r_data;
    logic        r_wr;

    initial begin
        cache_rdy = 1'b0; cache_hit = 1'b0; cache_data = '0;
        forever begin
            @(negedge clk);
            if (resp_en && (oRd || oWr)) begin
                r_addr = oAddr; r_data = oData; r_wr = oWr;
                repeat (resp_dly) @(posedge clk);
                #1;
                cache_hit = (mem.exists(r_addr) != 0);
                if (r_wr) begin
                    mem[r_addr] = r_data;
                    cache_data  = 32'hDEAD_BEEF;
                end else begin
                    if (mem.exists(r_addr) == 0) mem[r_addr] = 32'd0;
                    cache_data = mem[r_addr];
                end
                cache_rdy = 1'b1;
                @(posedge clk); #1;
                cache_rdy = 1'b0; cache_hit = 1'b0; cache_data = '0;
            end
        end
    end

    // Called at #1 after a rising edge; returns #1 after the push edge.
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        int k = 0;
        iReqValid = 1'b1; iReqWr = w; iReqAddr = a; iReqData = d;
        @(negedge clk);
        while (!oReqReady && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) check("push_ready_timeout", 32'(oReqReady), 32'd1);
        @(posedge clk); #1;
        iReqValid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] d, input logic h, input logic e);
        int k = 0;
        @(negedge clk);
        while (!oRspValid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_vld"},  32'(oRspValid), 32'd1);
        check({tag, "_data"}, oRspData, d);
        check({tag, "_hit"},  32'(oRspHit), 32'(h));
        check({tag, "_err"},  32'(oRspErr), 32'(e));
        iRspReady = 1'b1;
        @(posedge clk); #1;
        iRspReady = 1'b0;
    endtask

    task automatic pulse_ready(input logic h, input logic [31:0] d);
        man_rdy = 1'b1; man_hit = h; man_data = d;
        @(posedge clk); #1;
        man_rdy = 1'b0; man_hit = 1'b0; man_data = '0;
    endtask

    task automatic wait_issue(input string tag);
        int k = 0;
        @(negedge clk);
        while (!(oRd || oWr) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(oRd || oWr), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},   32'(oReqReady), 32'd0);
        check({tag, "_rdwr"},  32'({oRd, oWr}), 32'd0);
        check({tag, "_addr"},  oAddr, 32'd0);
        check({tag, "_wdata"}, oData, 32'd0);
        check({tag, "_rsp"},   32'({oRspValid, oRspHit, oRspErr}), 32'd0);
        check({tag, "_rdata"}, oRspData, 32'd0);
        check({tag, "_cnt"},   32'({oHitCnt, oMissCnt}), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        resetn = 1'b0; iReqValid = 1'b0; iReqWr = 1'b0; iReqAddr = '0; iReqData = '0;
        iRspReady = 1'b0; man_rdy = 1'b0; man_hit = 1'b0; man_data = '0;
        repeat (2) @(posedge clk); #1;
        check_all_zero("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Store miss with latency and single-cycle pulse checks.
        push(1'b1, 32'hFDEF_1000, 32'h1234_5678);
        @(negedge clk);
        check("t1_wr_early", 32'(oWr), 32'd0);
        @(negedge clk);
        check("t1_wr",    32'(oWr), 32'd1);
        check("t1_rd",    32'(oRd), 32'd0);
        check("t1_addr",  oAddr, 32'hFDEF_1000);
        check("t1_wdata", oData, 32'h1234_5678);
        @(negedge clk);
        check("t1_wr_pulse", 32'(oWr), 32'd0);
        check("t1_addr_off", oAddr, 32'd0);
        get_rsp("t1", 32'd0, 1'b0, 1'b0);
        check("t1_miss", 32'(oMissCnt), 32'd1);
        check("t1_hit",  32'(oHitCnt), 32'd0);

        // Load hit returns the stored word.
        push(1'b0, 32'hFDEF_1000, 32'd0);
        get_rsp("t2", 32'h1234_5678, 1'b1, 1'b0);
        check("t2_hitcnt", 32'(oHitCnt), 32'd1);

        // Timeout: response on the 9th cycle after ISSUE, counters untouched.
        resp_en = 1'b0;
        push(1'b0, 32'h0000_0200, 32'd0);
        wait_issue("t4_issue");
        n = 0;
        while (!oRspValid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("t4_latency", 32'(n), 32'd9);
        get_rsp("t4", 32'd0, 1'b0, 1'b1);
        check("t4_cnt", 32'({oHitCnt, oMissCnt}), 32'({2'd1, 2'd1}));
        pulse_ready(1'b0, 32'h5555_5555);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (oRspValid || oRd || oWr) seen++;
        end
        check("t4_late_ready", 32'(seen), 32'd0);
        check("t4_late_cnt", 32'({oHitCnt, oMissCnt}), 32'({2'd1, 2'd1}));
        resp_en = 1'b1;
        @(posedge clk); #1;

        // Back-pressure: one in flight, four queued, sixth refused; drain in order.
        push(1'b1, 32'h0000_0100, 32'hAAAA_0001);
        push(1'b0, 32'h0000_0100, 32'd0);
        push(1'b0, 32'h0000_0104, 32'd0);
        push(1'b1, 32'h0000_0104, 32'hBBBB_0004);
        push(1'b0, 32'h0000_0104, 32'd0);
        iReqValid = 1'b1; iReqWr = 1'b0; iReqAddr = 32'h0000_0108; iReqData = '0;
        @(negedge clk);
        check("t3_full", 32'(oReqReady), 32'd0);
        iReqValid = 1'b0;
        @(posedge clk); #1;
        get_rsp("t3_r1", 32'd0, 1'b0, 1'b0);
        push(1'b0, 32'h0000_0108, 32'd0);
        get_rsp("t3_r2", 32'hAAAA_0001, 1'b1, 1'b0);
        get_rsp("t3_r3", 32'd0,         1'b0, 1'b0);
        get_rsp("t3_r4", 32'd0,         1'b1, 1'b0);
        get_rsp("t3_r5", 32'hBBBB_0004, 1'b1, 1'b0);
        get_rsp("t3_r6", 32'd0,         1'b0, 1'b0);
        check("t3_hit_sat",  32'(oHitCnt),  32'd3);
        check("t3_miss_sat", 32'(oMissCnt), 32'd3);

        // Reset during WAIT with a second request queued.
        resp_en = 1'b0;
        push(1'b0, 32'h0000_0300, 32'd0);
        push(1'b1, 32'h0000_0304, 32'h0000_0001);
        wait_issue("t5_issue");
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_all_zero("t5_rst");
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        pulse_ready(1'b1, 32'h7777_7777);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (oRspValid || oRd || oWr) seen++;
        end
        check("t5_quiet", 32'(seen), 32'd0);
        check("t5_cnt", 32'({oHitCnt, oMissCnt}), 32'd0);
        check("t5_empty_rdy", 32'(oReqReady), 32'd1);

        // Idle iReady does nothing; then hit counter saturates at 3.
        @(posedge clk); #1;
        pulse_ready(1'b1, 32'h1111_1111);
        @(negedge clk);
        check("t6_idle_rsp", 32'(oRspValid), 32'd0);
        check("t6_idle_cnt", 32'(oHitCnt), 32'd0);
        @(posedge clk); #1;
        resp_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 32'hFDEF_1000, 32'd0);
            get_rsp("t6", 32'h1234_5678, 1'b1, 1'b0);
            check("t6_hitcnt", 32'(oHitCnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        check("t6_misscnt", 32'(oMissCnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule
